// File: rtl/i2c_bus_sequencer.sv
// rtl/i2c_bus_sequencer.sv - round-robin shared I2C master sequencing single-byte transactions
module i2c_bus_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 nack,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 scl_oe,
    output logic                 sda_oe,
    input  logic                 sda_i
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QLAST = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PLAST = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
        S_WACK, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   q_cnt;
    logic [1:0]      qtr, qtr_n;
    logic [2:0]      bit_cnt, bit_n;
    logic            tick, sample;
    logic [PW-1:0]   ptr, sel, cand;
    logic            found;
    int              idx;
    logic [6:0]      sel_addr, lat_addr;
    logic            sel_rw, lat_rw;
    logic [7:0]      sel_wdata, lat_wdata, rx_sr;
    logic [7:0]      addr_byte;
    logic            nack_flag;
    logic            scl_n, sda_n;

    assign tick      = (state != S_IDLE) && (q_cnt == QLAST);
    assign sample    = tick && (qtr == 2'd2);
    assign addr_byte = {lat_addr, lat_rw};

    // round-robin search: first request at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // select the candidate requester's transaction fields
    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == PW'(i)) begin
                sel_addr  = req_addr[i*7 +: 7];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // next state, quarter and bit position; transitions happen on the tick ending Q3
    always_comb begin
        state_n = state;
        qtr_n   = qtr;
        bit_n   = bit_cnt;
        if (state == S_IDLE) begin
            if (found) begin
                state_n = S_START;
                qtr_n   = 2'd0;
                bit_n   = 3'd0;
            end
        end else if (state == S_DONE) begin
            state_n = S_IDLE;
            qtr_n   = 2'd0;
            bit_n   = 3'd0;
        end else if (tick) begin
            qtr_n = qtr + 2'd1;
            if (qtr == 2'd3) begin
                case (state)
                    S_START: begin
                        state_n = S_ADDR;
                        bit_n   = 3'd0;
                    end
                    S_ADDR: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = S_ADDR_ACK;
                    end
                    S_ADDR_ACK: begin
                        bit_n   = 3'd0;
                        state_n = nack_flag ? S_STOP : (lat_rw ? S_RDATA : S_WDATA);
                    end
                    S_WDATA: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = S_WACK;
                    end
                    S_WACK:  state_n = S_STOP;
                    S_RDATA: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = S_MNACK;
                    end
                    S_MNACK: state_n = S_STOP;
                    S_STOP:  state_n = S_DONE;
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    // pad enables computed from the upcoming position so the registered outputs line up with it
    always_comb begin
        scl_n = 1'b0;
        sda_n = 1'b0;
        case (state_n)
            S_START: sda_n = qtr_n[1];
            S_ADDR: begin
                scl_n = ~qtr_n[1];
                sda_n = ~addr_byte[3'd7 - bit_n];
            end
            S_WDATA: begin
                scl_n = ~qtr_n[1];
                sda_n = ~lat_wdata[3'd7 - bit_n];
            end
            S_ADDR_ACK, S_WACK, S_RDATA, S_MNACK: scl_n = ~qtr_n[1];
            S_STOP: begin
                scl_n = (qtr_n == 2'd0);
                sda_n = ~qtr_n[1];
            end
            default: ;
        endcase
    end

    // state, bit-slot position and glitch-free pad enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            qtr     <= 2'd0;
            bit_cnt <= 3'd0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            qtr     <= qtr_n;
            bit_cnt <= bit_n;
            scl_oe  <= scl_n;
            sda_oe  <= sda_n;
        end
    end

    // quarter-period divider, idle at zero so START always begins a fresh quarter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            q_cnt <= '0;
        end else begin
            q_cnt <= q_cnt + 1'b1;
        end
    end

    // grant, request latching, bus sampling and completion reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            nack      <= 1'b0;
            rdata     <= '0;
            ptr       <= '0;
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            rx_sr     <= '0;
            nack_flag <= 1'b0;
        end else begin
            done <= '0;
            if (state == S_IDLE && found) begin
                gnt       <= ONE << sel;
                busy      <= 1'b1;
                ptr       <= (sel == PLAST) ? '0 : sel + 1'b1;
                lat_addr  <= sel_addr;
                lat_rw    <= sel_rw;
                lat_wdata <= sel_wdata;
            end
            if (sample && (state == S_ADDR_ACK || state == S_WACK) && sda_i) begin
                nack_flag <= 1'b1;
            end
            if (sample && state == S_RDATA) begin
                rx_sr <= {rx_sr[6:0], sda_i};
            end
            if (state == S_STOP && state_n == S_DONE) begin
                done <= gnt;
                nack <= nack_flag;
                if (lat_rw && !nack_flag) rdata <= rx_sr;
            end
            if (state == S_DONE) begin
                gnt       <= '0;
                busy      <= 1'b0;
                nack_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// tb/tb_i2c_bus_sequencer.sv - scoreboard bench for i2c_bus_sequencer
module tb_i2c_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] req_addr = '0;
    logic [3:0]  req_rw = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt, done;
    logic        nack, busy, scl_oe, sda_oe, sda_i;
    logic [7:0]  rdata;
    logic        slave_pull = 1'b0;

    i2c_bus_sequencer #(.NUM_REQ(4), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .nack(nack), .rdata(rdata),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    assign sda_i = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt1h;
        logic [7:0] abyte;
        logic       rw;
        logic [7:0] wbyte;
        logic [7:0] rbyte;
        logic       anack;
        logic       dnack;
        int         len;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] rdata_model = '0;

    int         cyc = 0, t0 = 0, off = 0, done_cnt = 0, last_done = 0;
    logic [3:0] prev_gnt = '0, cur_gnt = '0;
    logic [7:0] acap = '0, wcap = '0;
    logic       rd_drv = 1'b0, ack_drv = 1'b0, gnt_chg = 1'b0;
    logic       rr_mode = 1'b0, rr_armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // bus monitor, timing-based slave and scoreboard pop
    always @(negedge clk) begin
        int   s, ph;
        exp_t e;
        cyc++;
        if (gnt != 0 && prev_gnt == 0) begin
            t0 = cyc; cur_gnt = gnt; gnt_chg = 0;
            acap = '0; wcap = '0; rd_drv = 0; ack_drv = 0;
            if (exp_q.size() > 0) check("gnt_order", gnt, exp_q[0].gnt1h);
            if (rr_mode && rr_armed) check("rr_gap_le2", (cyc - last_done) <= 2, 1);
        end
        slave_pull = 1'b0;
        if (gnt != 0) begin
            off = cyc - t0;
            if (gnt != cur_gnt) gnt_chg = 1;
            if (off >= 16 && exp_q.size() > 0) begin
                e  = exp_q[0];
                s  = (off - 16) / 16;
                ph = (off - 16) % 16;
                if (s == 8) slave_pull = !e.anack;
                if (e.rw && !e.anack && s >= 9 && s <= 16) slave_pull = !e.rbyte[16 - s];
                if (!e.rw && !e.anack && s == 17) slave_pull = !e.dnack;
                if (ph == 9) begin
                    if (s < 8) acap[7 - s] = ~sda_oe;
                    if (!e.anack && s >= 9 && s <= 16) begin
                        if (e.rw) rd_drv = rd_drv | sda_oe;
                        else wcap[16 - s] = ~sda_oe;
                    end
                    if (s == 8 || (!e.anack && s == 17)) ack_drv = ack_drv | sda_oe;
                end
            end
        end
        if (done != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_idx", done, e.gnt1h);
                check("gnt_held", {gnt_chg, gnt == done}, 2'b01);
                check("len", off, e.len);
                check("nack", nack, e.anack | e.dnack);
                check("addr_bits", acap, e.abyte);
                if (!e.anack && !e.rw) check("wdata_bits", wcap, e.wbyte);
                if (e.rw && !e.anack) rdata_model = e.rbyte;
                check("sda_released", {rd_drv, ack_drv}, 0);
                check("rdata", rdata, rdata_model);
            end
            done_cnt++;
            last_done = cyc;
            rr_armed = rr_mode;
        end
        prev_gnt = gnt;
    end

    task automatic start_txn(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                             input logic [7:0] rb, input logic an, input logic dn, input logic push);
        exp_t e;
        if (push) begin
            e.gnt1h = 4'b0001 << i;
            e.abyte = {a, rw};
            e.rw    = rw;
            e.wbyte = wd;
            e.rbyte = rb;
            e.anack = an;
            e.dnack = rw ? 1'b0 : dn;
            e.len   = an ? 176 : 320;
            exp_q.push_back(e);
        end
        req_addr[i*7 +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[i*8 +: 8] = wd;
        req[i]              = 1'b1;
    endtask

    task automatic wait_dones(input int n);
        int target;
        target = done_cnt + n;
        for (int k = 0; k < n * 400 + 50 && done_cnt < target; k++) @(negedge clk);
        if (done_cnt < target) check("done_timeout", done_cnt, target);
        req = '0;
    endtask

    task automatic wait_gnt();
        for (int k = 0; k < 50 && gnt == 0; k++) @(negedge clk);
        if (gnt == 0) check("gnt_timeout", gnt, 1);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_outs", {gnt, done, busy, scl_oe, sda_oe, nack}, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_txn(0, 7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_dones(1);
        start_txn(2, 7'h3C, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0, 1'b1);
        wait_dones(1);
        start_txn(3, 7'h7F, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);
        wait_dones(1);

        rr_mode = 1'b1;
        start_txn(0, 7'h11, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
        start_txn(1, 7'h22, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b1);
        start_txn(2, 7'h33, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1);
        start_txn(3, 7'h44, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1);
        start_txn(0, 7'h11, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
        base = done_cnt;
        for (int k = 0; k < 2000 && done_cnt < base + 4; k++) @(negedge clk);
        if (done_cnt < base + 4) check("rr_timeout", done_cnt, base + 4);
        repeat (4) @(negedge clk);
        req = '0;
        rr_mode = 1'b0;
        wait_dones(1);

        start_txn(1, 7'h2D, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_gnt();
        @(negedge clk);
        req_addr[13:7]  = 7'h55;
        req_wdata[15:8] = 8'hFF;
        wait_dones(1);

        start_txn(2, 7'h2A, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_gnt();
        for (int k = 0; k < 200 && (cyc - t0) != 70; k++) @(negedge clk);
        check("reached_bit3", cyc - t0, 70);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_outs", {scl_oe, sda_oe, gnt, busy, done}, 0);
        check("rst_mid_rdata", rdata, 0);
        req = '0;
        rdata_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_txn(1, 7'h0A, 1'b0, 8'h66, 8'h00, 1'b0, 1'b0, 1'b1);
        start_txn(3, 7'h0B, 1'b1, 8'h00, 8'h3E, 1'b0, 1'b0, 1'b1);
        wait_dones(2);
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/i2c_bus_sequencer.md
Name: i2c_bus_sequencer

Overview:
- Shares one I2C bus master between NUM_REQ on-chip requesters using round-robin arbitration.
- Sequences each granted single-byte transaction (write or read) at bit level: START, 7-bit address + R/W, ACK check, data byte, ACK/NACK, STOP.
- Drives open-drain SCL/SDA enables and returns status to the granted requester.
- Sits between the requester logic and the I2C pad drivers; it is the DUT exercised through the dut_if/test_if bench harness.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV, 4, clk cycles per SCL quarter-period (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester transaction request, level, held until done
- req_addr  in  NUM_REQ*7  target address; requester i uses bits [7i+6:7i]
- req_rw  in  NUM_REQ  1=read, 0=write
- req_wdata  in  NUM_REQ*8  write byte; requester i uses bits [8i+7:8i]
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle pulse to the granted requester at completion
- nack  out  1  valid with done; 1 = address or write-data NACKed
- rdata  out  8  read byte, valid with done for reads; holds until the next read completes
- busy  out  1  transaction in progress
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset (asynchronous, immediate): gnt=0, done=0, nack=0, rdata=0, busy=0, scl_oe=0, sda_oe=0, round-robin pointer=0, state=IDLE. Reset mid-transaction releases the bus at once; no STOP is generated.
- Quarter tick: a counter 0..CLK_DIV-1 runs while state is not IDLE. It pulses at wrap and is cleared on entry to START.
- Arbitration in IDLE with any req set: grant the first set req at or after the pointer, searching upward with wrap. The pointer becomes granted+1 mod NUM_REQ. gnt and busy rise on the next clk edge.
- The granted requester's addr, rw and wdata are latched at grant. Later changes are ignored. Deasserting req mid-transaction does not abort it.
- Each state lasts a whole number of quarters (Q0..Q3). Bit slot:
  - Q0: SCL low; SDA updated at Q0 entry.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - SDA is sampled on the tick ending Q2.
- START (4 quarters): SDA and SCL released for Q0–Q1, SDA low for Q2–Q3, then go to ADDR.
- ADDR (8 bits): shifts {addr, rw} MSB first. sda_oe = ~bit.
- ADDR_ACK (1 bit): SDA released. Sampled 1 → nack_flag=1, go to STOP. Sampled 0 → go to WDATA or RDATA.
- WDATA (8 bits): shifts wdata MSB first, then WACK (1 bit). Sampled 1 sets nack_flag. Then go to STOP.
- RDATA (8 bits): SDA released. Sampled bits shift in MSB first. Then MNACK (1 bit): SDA released, master NACK. Then go to STOP.
- STOP (4 quarters):
  - Q0: SCL low, SDA low.
  - Q1: SCL released, SDA low.
  - Q2–Q3: SDA released.
  - Then go to DONE.
- DONE (1 clk): done[granted]=1, nack=nack_flag. For reads with no NACK, rdata is updated. gnt and busy clear on the following edge, state=IDLE, nack_flag cleared. The next arbitration can grant on the cycle after IDLE entry.
- Full transaction length is 4+36+36+4 = 80 quarters = 80*CLK_DIV clk cycles from START entry to DONE. An address NACK shortens it to 44*CLK_DIV.
- No clock stretching and no multi-master arbitration. sda_i is only sampled at the defined points.
- scl_oe and sda_oe are registered outputs (glitch-free).

Test Plan:
- Single write: CLK_DIV=4, req[0] with addr=0x50, rw=0, wdata=0xA5, slave ACKs.
  - SDA bits 1010000 0 at ADDR, then 10100101 at WDATA.
  - done[0] exactly 320 cycles after START entry, nack=0.
- Single read: req[2] with addr=0x3C, rw=1, slave drives 0x96 in RDATA.
  - rdata=0x96 with done[2], nack=0.
  - SDA released at MNACK.
- Address NACK: sda_i held high at ADDR_ACK.
  - Goes straight to STOP; done at 176 cycles, nack=1.
  - Data byte never driven; rdata unchanged.
- Round-robin: req=4'b1111 held continuously.
  - Grant order 0,1,2,3,0; each gnt is one-hot and lasts a whole transaction.
  - No gap greater than 2 cycles between done and the next gnt.
- Reset mid-ADDR: assert rst_n=0 at bit 3.
  - scl_oe=0, sda_oe=0, gnt=0 and busy=0 in the same cycle, no done pulse.
  - After release with req[1] set, the next grant is req[1] (pointer reset to 0, req[0] clear).
- Latching check: change req_wdata and req_addr one cycle after grant.
  - Bus shows the original values; the write data NACK still completes STOP with nack=1.
